// File: rtl/codec_intf.sv
// codec_intf: CS4272 I2S link. Generates MCLK/SCLK/LRCLK/RSTn from clk,
// deserializes SDout into lft_rd/rht_rd (valid pulse) and serializes
// lft_wrt/rht_wrt (captured on valid) onto SDin in the following frame.
// Ports: clk, rst_n (async, active low); lft_wrt, rht_wrt, SDout in;
//        lft_rd, rht_rd, valid, MCLK, SCLK, LRCLK, SDin, RSTn out.
module codec_intf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lft_wrt,
  input  logic [15:0] rht_wrt,
  input  logic        SDout,
  output logic [15:0] lft_rd,
  output logic [15:0] rht_rd,
  output logic        valid,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        SDin,
  output logic        RSTn
);

  logic [10:0] cnt;
  logic [10:0] cnt_nxt;
  logic [4:0]  k;
  logic        rise;
  logic        fall;
  logic        word_bit;
  logic [15:0] rx_shft;
  logic [15:0] rx_nxt;
  logic [15:0] lft_hold;
  logic [15:0] lft_tx;
  logic [15:0] rht_tx;
  logic [15:0] tx_shft;
  logic [15:0] tx_nxt;

  assign cnt_nxt  = cnt + 11'd1;
  assign k        = cnt[9:5];
  assign rise     = (cnt[4:0] == 5'b01111);
  assign fall     = (cnt[4:0] == 5'b11111);
  assign word_bit = (k >= 5'd1) && (k <= 5'd16);
  assign rx_nxt   = {rx_shft[14:0], SDout};

  // Word load at the fall ending k=0, then shift out with zero fill.
  always_comb begin
    tx_nxt = tx_shft;
    if (fall) begin
      if (k == 5'd0)
        tx_nxt = cnt[10] ? rht_tx : lft_tx;
      else
        tx_nxt = {tx_shft[14:0], 1'b0};
    end
  end

  // Clock outputs follow the counter value of the cycle they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 11'd0;
      MCLK  <= 1'b0;
      SCLK  <= 1'b0;
      LRCLK <= 1'b0;
      RSTn  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      MCLK  <= cnt_nxt[1];
      SCLK  <= cnt_nxt[4];
      LRCLK <= cnt_nxt[10];
      if (cnt == 11'h7FF)
        RSTn <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft  <= 16'd0;
      lft_hold <= 16'd0;
      lft_rd   <= 16'd0;
      rht_rd   <= 16'd0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise && word_bit)
        rx_shft <= rx_nxt;
      if (cnt == 11'h20F)
        lft_hold <= rx_nxt;
      // Last right bit goes straight to rht_rd with the valid pulse.
      if (cnt == 11'h60F) begin
        lft_rd <= lft_hold;
        rht_rd <= rx_nxt;
        valid  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_tx  <= 16'd0;
      rht_tx  <= 16'd0;
      tx_shft <= 16'd0;
      SDin    <= 1'b0;
    end else begin
      if (valid) begin
        lft_tx <= lft_wrt;
        rht_tx <= rht_wrt;
      end
      tx_shft <= tx_nxt;
      SDin    <= tx_nxt[15];
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: random stimulus, frame-level reference model and a
// scoreboard queue popped by a monitor on every valid pulse.
module tb_codec_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lft_wrt = 16'd0;
  logic [15:0] rht_wrt = 16'd0;
  logic [15:0] lft_rd;
  logic [15:0] rht_rd;
  logic        sdout;
  logic        valid;
  logic        mclk;
  logic        sclk;
  logic        lrclk;
  logic        sdin;
  logic        rstn;
  logic        sd_m = 1'b0;
  logic        mode = 1'b0;
  logic        first_cw = 1'b0;

  int t = 0;
  int checks = 0;
  int errors = 0;
  int nvalid = 0;

  logic [15:0] this_l = 16'd0;
  logic [15:0] this_r = 16'd0;
  logic [15:0] prev_l = 16'd0;
  logic [15:0] prev_r = 16'd0;
  logic [15:0] cw_l = 16'd0;
  logic [15:0] cw_r = 16'd0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign sdout = mode ? sd_m : sdin;

  codec_intf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lft_wrt (lft_wrt),
    .rht_wrt (rht_wrt),
    .SDout   (sdout),
    .lft_rd  (lft_rd),
    .rht_rd  (rht_rd),
    .valid   (valid),
    .MCLK    (mclk),
    .SCLK    (sclk),
    .LRCLK   (lrclk),
    .SDin    (sdin),
    .RSTn    (rstn)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0d act=%h req=%h", name, t, act, req);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_lft_rd"}, {16'd0, lft_rd}, 32'd0);
    chk({p, "_rht_rd"}, {16'd0, rht_rd}, 32'd0);
    chk({p, "_valid"}, {31'd0, valid}, 32'd0);
    chk({p, "_MCLK"}, {31'd0, mclk}, 32'd0);
    chk({p, "_SCLK"}, {31'd0, sclk}, 32'd0);
    chk({p, "_LRCLK"}, {31'd0, lrclk}, 32'd0);
    chk({p, "_SDin"}, {31'd0, sdin}, 32'd0);
    chk({p, "_RSTn"}, {31'd0, rstn}, 32'd0);
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (t != target && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (t != target) begin
      checks++;
      errors++;
      $display("FAIL wait_t t=%0d req=%0d", t, target);
    end
  endtask

  // Clocks since reset release; equals the codec frame position mod 2048.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      t <= 0;
    else
      t <= t + 1;
  end

  // Frame-level model, stimulus and per-cycle output checks.
  always @(negedge clk) begin
    if (rst_n) begin
      int c;
      int k;
      logic [15:0] wtx;
      logic [15:0] wcw;
      logic        e_sd;
      c = t % 2048;
      k = (c / 32) % 32;
      if (c == 0) begin
        prev_l = this_l;
        prev_r = this_r;
        if (first_cw) begin
          cw_l = 16'hCE00;
          cw_r = 16'h3200;
          first_cw = 1'b0;
        end else begin
          cw_l = 16'($urandom);
          cw_r = 16'($urandom);
        end
        if (mode)
          exp_q.push_back({cw_l, cw_r});
        else
          exp_q.push_back({prev_l, prev_r});
      end
      wtx = (c >= 1024) ? prev_r : prev_l;
      wcw = (c >= 1024) ? cw_r : cw_l;
      e_sd = (k >= 1 && k <= 16) ? wtx[16-k] : 1'b0;
      sd_m = (k >= 1 && k <= 16) ? wcw[16-k] : 1'b0;
      chk("MCLK", {31'd0, mclk}, 32'((c / 2) % 2));
      chk("SCLK", {31'd0, sclk}, 32'((c / 16) % 2));
      chk("LRCLK", {31'd0, lrclk}, 32'(c / 1024));
      chk("RSTn", {31'd0, rstn}, {31'd0, t >= 2048});
      chk("valid_pos", {31'd0, valid}, {31'd0, c == 1552});
      chk("SDin", {31'd0, sdin}, {31'd0, e_sd});
      lft_wrt = 16'($urandom);
      rht_wrt = 16'($urandom);
      if (c == 1552) begin
        this_l = lft_wrt;
        this_r = rht_wrt;
      end
    end
  end

  // Monitor: every valid pulse consumes one expected word pair.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      logic [31:0] e;
      nvalid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL valid_unexpected t=%0d act=1 req=0", t);
      end else begin
        e = exp_q.pop_front();
        chk("lft_rd", {16'd0, lft_rd}, {16'd0, e[31:16]});
        chk("rht_rd", {16'd0, rht_rd}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Loopback run, then a mid-left-slot reset at 0x300.
    wait_t(5 * 2048 + 'h300);
    #1 rst_n = 1'b0;
    #1 chk_reset("mid");
    chk("nvalid_loop", nvalid, 32'd5);
    exp_q.delete();
    this_l = 16'd0;
    this_r = 16'd0;
    prev_l = 16'd0;
    prev_r = 16'd0;
    nvalid = 0;
    mode = 1'b1;
    first_cw = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Codec-model run; first frame sends -12800 / +12800.
    wait_t(4 * 2048 + 16);
    chk("nvalid_codec", nvalid, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_intf.md
# codec_intf

Serial interface between the equalizer datapath and the CS4272 audio codec. It generates the codec clocks (MCLK, SCLK, LRCLK) and the codec reset from the 50 MHz system clock. It deserializes the codec's SDout stream into 16-bit left/right samples and serializes processed left/right samples onto SDin. Fixed 2048-clock frame gives 24414 Hz sample rate, which the equalizer filters and codec-level benches depend on.

## Interface

- No parameters; all divide ratios are fixed.
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- lft_wrt  in  16  signed left sample to send; captured on `valid`
- rht_wrt  in  16  signed right sample to send; captured on `valid`
- SDout  in  1  serial data from codec
- lft_rd  out  16  signed left sample received, held between `valid` pulses
- rht_rd  out  16  signed right sample received, held between `valid` pulses
- valid  out  1  one-clock pulse once per frame when lft_rd/rht_rd update
- MCLK  out  1  clk/4
- SCLK  out  1  clk/32
- LRCLK  out  1  clk/2048; low = left slot, high = right slot
- SDin  out  1  serial data to codec
- RSTn  out  1  codec reset, active low

## Operation

- Free-running 11-bit counter `cnt`, reset 0, +1 every clk, wraps 0x7FF→0.
- Clock outputs are registered from counter bits: MCLK = cnt[1], SCLK = cnt[4], LRCLK = cnt[10].
- Slot bit index k = cnt[9:5] (0..31). 32 SCLKs per slot; 64 per frame.
- SCLK rise cycle (RISE): cnt[4:0]==5'b01111. SCLK fall cycle (FALL): cnt[4:0]==5'b11111.
- Format is I2S, MSB first, 1-SCLK delay after each LRCLK edge. Word bits occupy k=1..16. All other k carry 0 on SDin; SDout is ignored there.
- Receive:
  - On RISE with 1≤k≤16, shift SDout into rx_shft[15:0] LSB, shifting left.
  - At RISE k=16 of the left slot (cnt=0x20F), copy rx_shft to lft_hold.
  - At RISE k=16 of the right slot (cnt=0x60F), the next clock sets lft_rd=lft_hold, rht_rd=rx_shft, and pulses valid.
- Transmit:
  - On valid, capture lft_wrt/rht_wrt into lft_tx/rht_tx.
  - At FALL with k=0 (start of bit 1), load tx_shft with lft_tx (left slot) or rht_tx (right slot).
  - At each later FALL, shift left with 0 fill.
  - SDin = tx_shft[15], registered, so it changes only after SCLK falls.
- Samples captured on valid of frame N are transmitted in frame N+1.
- RSTn: low from reset until the first counter wrap, i.e. the first 2048 clocks. Set high when cnt goes 0x7FF→0 and stays high until the next rst_n assertion.

## Timing

- Reset values: cnt=0, MCLK=SCLK=LRCLK=0, SDin=0, RSTn=0, valid=0, lft_rd=rht_rd=0, all shift/hold regs 0.
- Reset is asynchronous at any point, including mid-frame. All state returns to reset values immediately, and the frame restarts at cnt=0 after release. A partial word is discarded, not emitted.
- valid period is exactly 2048 clks; it is asserted in the cycle where cnt==0x610.
- Receive latency: the last SDout bit of a right word is sampled at cnt=0x60F and appears on rht_rd at the clk edge where valid rises.
- lft_wrt/rht_wrt need to be stable only in the valid cycle; changes at other times have no effect.
- valid and the first word load (cnt=0x01F) never coincide.
- The first valid after reset carries data from the first frame. That data is meaningless while RSTn=0, but valid is not suppressed.

## Test plan

- Release reset, run 4096 clks. Required: MCLK period 4, SCLK period 32, LRCLK period 2048, LRCLK=0 for cnt<0x400. RSTn rises at clk 2048. valid is high exactly once per 2048 clks, at cnt==0x610.
- Loopback SDin→SDout with lft_wrt=16'h1234, rht_wrt=16'hA5C3. Required: from the third valid on, lft_rd=16'h1234 and rht_rd=16'hA5C3.
- Drive SDout from a CS4272 model sending left=-12800, right=+12800. Required: lft_rd=16'hCE00 and rht_rd=16'h3200 at the next valid.
- Check SDin bit positions with lft_wrt=16'h8001. Required: SDin=1 during left-slot SCLK periods k=1 and k=16, and 0 elsewhere in that slot. SDin transitions occur only on clks after SCLK falls.
- Assert rst_n at cnt=0x300, mid left slot, for 5 clks. Required: all outputs return to reset values asynchronously, and RSTn goes low again. The next valid occurs 0x610 clks after release, with no partial word emitted.
- Change lft_wrt every clk except in the valid cycle. Required: only the value present in the valid cycle is serialized in the following frame.
